pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// in_ready comes straight from state, so there is no combinational path from out_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int NCH    = 3,
    parameter int CTRL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [1:0]            occupancy
);

    // The state encoding is also the held-entry count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CTRL_W-1:0]     main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0]     skid_ctrl_q, skid_ctrl_d;
    logic [NCH*DATA_W-1:0] main_data_q;
    logic [NCH*DATA_W-1:0] skid_data_q;

    logic accept;
    logic take;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && take) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d      = ST_FULL;
                    load_skid_in = 1'b1;
                end else if (take) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (take) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush squashes everything held and drops the offered entry; data
        // may still load but its ctrl is forced to zero, so it is inert.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;
        if (load_main_in) begin
            main_ctrl_d = in_ctrl;
        end else if (load_main_skid) begin
            main_ctrl_d = skid_ctrl_q;
        end
        if (load_skid_in) begin
            skid_ctrl_d = in_ctrl;
        end
        if (flush) begin
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // Per-channel data registers; load enables are shared across channels.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [DATA_W-1:0] main_d;
            logic [DATA_W-1:0] skid_d;

            always_comb begin
                main_d = main_data_q[gi*DATA_W +: DATA_W];
                skid_d = skid_data_q[gi*DATA_W +: DATA_W];
                if (load_main_in) begin
                    main_d = in_data[gi*DATA_W +: DATA_W];
                end else if (load_main_skid) begin
                    main_d = skid_data_q[gi*DATA_W +: DATA_W];
                end
                if (load_skid_in) begin
                    skid_d = in_data[gi*DATA_W +: DATA_W];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_data_q[gi*DATA_W +: DATA_W] <= '0;
                    skid_data_q[gi*DATA_W +: DATA_W] <= '0;
                end else begin
                    main_data_q[gi*DATA_W +: DATA_W] <= main_d;
                    skid_data_q[gi*DATA_W +: DATA_W] <= skid_d;
                end
            end
        end
    endgenerate

endmodule
